// File: rtl/mem_stage_pipe.sv
// EX->MEM stage register: one-cycle accept-to-output latency, full throughput.
// SKID=1 parks one extra entry so in_ready is registered; SKID=0 passes out_ready straight to in_ready.
module mem_stage_pipe #(
  parameter int PC_W   = 30,
  parameter int INSN_W = 32,
  parameter int GPR_W  = 32,
  parameter int RA_W   = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16,
  parameter logic [INSN_W-1:0] NOP_INSN = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              in_en,
  input  logic [GPR_W-1:0]  in_alu_out,
  input  logic              in_gpr_we_,
  input  logic [RA_W-1:0]   in_dst_addr,
  input  logic [GPR_W-1:0]  in_mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INSN_W-1:0] out_insn,
  output logic              out_en,
  output logic [GPR_W-1:0]  out_alu_out,
  output logic              out_gpr_we_,
  output logic [RA_W-1:0]   out_dst_addr,
  output logic [GPR_W-1:0]  out_mem_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
    logic              en;
    logic [GPR_W-1:0]  alu_out;
    logic              gpr_we_;
    logic [RA_W-1:0]   dst_addr;
    logic [GPR_W-1:0]  mem_data;
  } entry_t;

  localparam entry_t BUBBLE = '{pc: '0, insn: NOP_INSN, en: 1'b0, alu_out: '0,
                                gpr_we_: 1'b1, dst_addr: '0, mem_data: '0};

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_e;
  logic             rdy_q;
  logic [CNT_W-1:0] stall_q;
  logic             accept;
  logic             emit;

  assign in_e = '{pc: in_pc, insn: in_insn, en: in_en, alu_out: in_alu_out,
                  gpr_we_: in_gpr_we_, dst_addr: in_dst_addr, mem_data: in_mem_data};

  assign out_valid = (state != EMPTY);
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign occupancy = state;
  assign stall_cnt = stall_q;

  assign out_pc       = main_q.pc;
  assign out_insn     = main_q.insn;
  assign out_en       = main_q.en;
  assign out_alu_out  = main_q.alu_out;
  assign out_gpr_we_  = main_q.gpr_we_;
  assign out_dst_addr = main_q.dst_addr;
  assign out_mem_data = main_q.mem_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
      stall_q <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush) begin
        state  <= EMPTY;
        main_q <= BUBBLE;
        skid_q <= BUBBLE;
        rdy_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_q <= in_e;
              state  <= ONE;
            end
          end
          ONE: begin
            if (accept && emit) begin
              main_q <= in_e;
            end else if (accept && SKID != 0) begin
              skid_q <= in_e;
              state  <= TWO;
              rdy_q  <= 1'b0;
            end else if (emit) begin
              main_q <= BUBBLE;
              state  <= EMPTY;
            end
          end
          TWO: begin
            // skid always drains into main, preserving FIFO order
            if (emit) begin
              main_q <= skid_q;
              skid_q <= BUBBLE;
              state  <= ONE;
              rdy_q  <= 1'b1;
            end
          end
          default: begin
            state <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Drives three stage configurations with shared random traffic; a queue model per instance scores outputs.
module tb_mem_stage_pipe;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        en;
    logic [31:0] alu_out;
    logic        gpr_we_;
    logic [4:0]  dst_addr;
    logic [31:0] mem_data;
  } entry_t;

  localparam entry_t BUB = '{pc: '0, insn: 32'h00000013, en: 1'b0, alu_out: '0,
                             gpr_we_: 1'b1, dst_addr: '0, mem_data: '0};

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [29:0] in_pc;
  logic [31:0] in_insn;
  logic        in_en;
  logic [31:0] in_alu_out;
  logic        in_gpr_we_;
  logic [4:0]  in_dst_addr;
  logic [31:0] in_mem_data;
  entry_t      cur_in;

  int errors = 0;
  int checks = 0;

  assign cur_in = '{in_pc, in_insn, in_en, in_alu_out, in_gpr_we_, in_dst_addr, in_mem_data};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int inst, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int SK = (g == 2) ? 0 : 1;
    localparam int CW = (g == 1) ? 2 : 16;

    logic          rdy;
    logic          ov;
    logic [1:0]    occ;
    logic [CW-1:0] st;
    logic [29:0]   opc;
    logic [31:0]   oin;
    logic          oen;
    logic [31:0]   oalu;
    logic          owe;
    logic [4:0]    odst;
    logic [31:0]   omem;

    mem_stage_pipe #(.SKID(SK), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy),
      .in_pc(in_pc), .in_insn(in_insn), .in_en(in_en), .in_alu_out(in_alu_out),
      .in_gpr_we_(in_gpr_we_), .in_dst_addr(in_dst_addr), .in_mem_data(in_mem_data),
      .out_valid(ov), .out_ready(out_ready),
      .out_pc(opc), .out_insn(oin), .out_en(oen), .out_alu_out(oalu),
      .out_gpr_we_(owe), .out_dst_addr(odst), .out_mem_data(omem),
      .occupancy(occ), .stall_cnt(st)
    );

    entry_t q[$];
    int     cnt;

    always @(negedge clk) begin
      entry_t act;
      entry_t hd;
      bit     erdy;
      int     sz;
      if (reset) begin
        q.delete();
        cnt = 0;
      end else begin
        sz   = q.size();
        erdy = (SK != 0) ? (sz < 2) : (sz == 0 || out_ready);
        act  = '{opc, oin, oen, oalu, owe, odst, omem};
        hd   = (sz > 0) ? q[0] : BUB;
        chk("occupancy", g, 160'(occ), 160'(sz));
        chk("out_valid", g, 160'(ov), 160'(sz != 0));
        chk("in_ready", g, 160'(rdy), 160'(erdy));
        chk("stall_cnt", g, 160'(st), 160'(cnt));
        chk("head", g, 160'(act), 160'(hd));
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (flush) q.delete();
        else if (in_valid && erdy) q.push_back(cur_in);
        if (sz > 0 && !out_ready && !flush && cnt < (1 << CW) - 1) cnt++;
      end
    end
  end

  task automatic drive(input bit v, input bit r, input bit f, input logic [29:0] pc);
    in_valid    = v;
    out_ready   = r;
    flush       = f;
    in_pc       = pc;
    in_insn     = $urandom;
    in_en       = 1'($urandom);
    in_alu_out  = $urandom;
    in_gpr_we_  = 1'($urandom);
    in_dst_addr = 5'($urandom);
    in_mem_data = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int p_rdy;
    int p_vld;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    step();
    // back-to-back stream with the consumer always ready
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 30'h10 + 30'(i));
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 30'h0);
    step();
    step();
    // blocked consumer: fill, hold, then drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 30'h20 + 30'(i));
      step();
    end
    repeat (4) begin
      drive(1'b1, 1'b0, 1'b0, 30'h22);
      step();
    end
    repeat (4) begin
      drive(1'b1, 1'b1, 1'b0, 30'h22);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 30'h0);
    step();
    step();
    // fill to two, then flush while offering a new entry
    drive(1'b1, 1'b0, 1'b0, 30'h30);
    step();
    drive(1'b1, 1'b0, 1'b0, 30'h31);
    step();
    drive(1'b1, 1'b0, 1'b1, 30'h32);
    step();
    drive(1'b0, 1'b1, 1'b0, 30'h0);
    step();
    step();
    p_rdy = 50;
    p_vld = 50;
    for (int c = 0; c < 1600; c++) begin
      if (c % 40 == 0) begin
        p_rdy = $urandom_range(0, 100);
        p_vld = $urandom_range(20, 100);
      end
      drive($urandom_range(0, 99) < p_vld, $urandom_range(0, 99) < p_rdy,
            $urandom_range(0, 99) < 3, 30'($urandom));
      reset = (c == 800);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 30'h0);
    step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
